// File: rtl/baccarat_pkg.sv
// Shared definitions for the baccarat display checker.
//   - Active-low seven-segment patterns ({g,f,e,d,c,b,a}) for every card rank.
//   - Rank enum, FSM state enum, error codes.
//   - seg_to_rank: pattern -> rank plus a bad-pattern flag.
//   - rank_value:  rank -> baccarat point value.
//   - hand_score:  three card values -> score mod 10.
package baccarat_pkg;

    localparam int NUM_HEX   = 6;
    localparam int NUM_SLOTS = 6;
    localparam int LED_W     = 10;
    localparam int BUS_W     = NUM_HEX * 7 + LED_W;

    // The bus idles with every digit blank and every light off.
    localparam logic [BUS_W-1:0] BUS_RST = {{LED_W{1'b0}}, {(NUM_HEX * 7){1'b1}}};

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ACE   = 7'h08;
    localparam logic [6:0] SEG_TWO   = 7'h24;
    localparam logic [6:0] SEG_THREE = 7'h30;
    localparam logic [6:0] SEG_FOUR  = 7'h19;
    localparam logic [6:0] SEG_FIVE  = 7'h12;
    localparam logic [6:0] SEG_SIX   = 7'h02;
    localparam logic [6:0] SEG_SEVEN = 7'h78;
    localparam logic [6:0] SEG_EIGHT = 7'h00;
    localparam logic [6:0] SEG_NINE  = 7'h10;
    localparam logic [6:0] SEG_TEN   = 7'h40;
    localparam logic [6:0] SEG_JACK  = 7'h61;
    localparam logic [6:0] SEG_QUEEN = 7'h18;
    localparam logic [6:0] SEG_KING  = 7'h09;

    typedef enum logic [3:0] {
        BLANK = 4'd0, ACE, TWO, THREE, FOUR, FIVE, SIX, SEVEN,
        EIGHT, NINE, TEN, JACK, QUEEN, KING
    } rank_t;

    typedef enum logic [1:0] {S_IDLE, S_DEAL, S_DONE} state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BADSEG   = 3'd1;
    localparam logic [2:0] ERR_ORDER    = 3'd2;
    localparam logic [2:0] ERR_SCORE    = 3'd3;
    localparam logic [2:0] ERR_WINNER   = 3'd4;
    localparam logic [2:0] ERR_EARLYWIN = 3'd5;

    typedef struct packed {
        logic       bad;
        logic [3:0] rank;
    } seg_dec_t;

    function automatic seg_dec_t seg_to_rank(input logic [6:0] seg);
        seg_dec_t d;
        d.bad = 1'b0;
        case (seg)
            SEG_BLANK: d.rank = BLANK;
            SEG_ACE:   d.rank = ACE;
            SEG_TWO:   d.rank = TWO;
            SEG_THREE: d.rank = THREE;
            SEG_FOUR:  d.rank = FOUR;
            SEG_FIVE:  d.rank = FIVE;
            SEG_SIX:   d.rank = SIX;
            SEG_SEVEN: d.rank = SEVEN;
            SEG_EIGHT: d.rank = EIGHT;
            SEG_NINE:  d.rank = NINE;
            SEG_TEN:   d.rank = TEN;
            SEG_JACK:  d.rank = JACK;
            SEG_QUEEN: d.rank = QUEEN;
            SEG_KING:  d.rank = KING;
            default: begin
                d.rank = BLANK;
                d.bad  = 1'b1;
            end
        endcase
        return d;
    endfunction

    // ACE..NINE encode as 1..9, so the rank code is the point value.
    function automatic logic [3:0] rank_value(input logic [3:0] r);
        return (r >= ACE && r <= NINE) ? r : 4'd0;
    endfunction

    // Max sum is 27, so two conditional subtracts always land in 0..9.
    function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] s;
        s = 5'(a) + 5'(b) + 5'(c);
        if (s >= 5'd10) s = s - 5'd10;
        if (s >= 5'd10) s = s - 5'd10;
        return s[3:0];
    endfunction

endpackage

// File: rtl/hex_stable_sampler.sv
// Synchronises an asynchronous parallel bus and accepts it as a snapshot once
// it has held still long enough.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus_in       : raw asynchronous bus
//   snap         : last accepted snapshot (resets to RST_VAL)
//   snap_valid   : one-cycle pulse when snap takes a new value
module hex_stable_sampler #(
    parameter int           W             = 52,
    parameter int           STABLE_CYCLES = 8,
    parameter int           SYNC_STAGES   = 2,
    parameter logic [W-1:0] RST_VAL       = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] bus_in,
    output logic [W-1:0] snap,
    output logic         snap_valid
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  prev_q;
    logic [7:0]                    cnt_q;
    logic [W-1:0]                  sync_bus;
    logic                          accept;

    assign sync_bus = sync_q[SYNC_STAGES-1];
    // The equality term keeps a change landing on a saturated counter from
    // being accepted before it has itself been stable.
    assign accept   = (cnt_q == STABLE) && (sync_bus == prev_q) && (sync_bus != snap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= {SYNC_STAGES{RST_VAL}};
            prev_q     <= RST_VAL;
            cnt_q      <= '0;
            snap       <= RST_VAL;
            snap_valid <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus_in};
            prev_q     <= sync_bus;
            snap_valid <= accept;
            if (sync_bus != prev_q)
                cnt_q <= '0;
            else if (cnt_q != STABLE)
                cnt_q <= cnt_q + 8'd1;
            if (accept)
                snap <= sync_bus;
        end
    end

endmodule

// File: rtl/baccarat_hex_checker.sv
// Passive checker for the baccarat display bus. Samples HEX5..HEX0 and LEDR,
// decodes cards, tracks deal order, recomputes scores and winner, and latches
// the first inconsistency.
//   CLOCK_50, resetb        : clock, asynchronous active-low reset
//   HEX0..HEX5, LEDR        : observed display bus
//   snap_valid              : pulse when a new snapshot is accepted
//   pscore_exp, dscore_exp  : recomputed hand scores
//   round_done, rounds      : round-complete pulse and saturating round count
//   err, err_code           : sticky error flag and first error code
module baccarat_hex_checker
    import baccarat_pkg::*;
#(
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       CLOCK_50,
    input  logic       resetb,
    input  logic [6:0] HEX0,
    input  logic [6:0] HEX1,
    input  logic [6:0] HEX2,
    input  logic [6:0] HEX3,
    input  logic [6:0] HEX4,
    input  logic [6:0] HEX5,
    input  logic [9:0] LEDR,
    output logic       snap_valid,
    output logic [3:0] pscore_exp,
    output logic [3:0] dscore_exp,
    output logic       round_done,
    output logic [7:0] rounds,
    output logic       err,
    output logic [2:0] err_code
);

    logic [BUS_W-1:0] snap;

    hex_stable_sampler #(
        .W             (BUS_W),
        .STABLE_CYCLES (STABLE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES),
        .RST_VAL       (BUS_RST)
    ) u_sampler (
        .clk        (CLOCK_50),
        .rst_n      (resetb),
        .bus_in     ({LEDR, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}),
        .snap       (snap),
        .snap_valid (snap_valid)
    );

    // Slots in deal order: p1, d1, p2, d2, p3, d3.
    logic [NUM_SLOTS-1:0][6:0] slot_seg;
    logic [LED_W-1:0]          led;

    assign slot_seg = {snap[35 +: 7], snap[14 +: 7], snap[28 +: 7],
                       snap[7 +: 7],  snap[21 +: 7], snap[0 +: 7]};
    assign led      = snap[BUS_W-1 -: LED_W];

    state_t                    state_q, state_d;
    logic [NUM_SLOTS-1:0][3:0] slot_q, slot_d, new_rank;
    logic [NUM_SLOTS-1:0]      bad, filled, chg;

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        seg_dec_t dec;
        assign dec         = seg_to_rank(slot_seg[k]);
        assign new_rank[k] = dec.rank;
        assign bad[k]      = dec.bad;
        assign filled[k]   = (dec.rank != BLANK);
        // A held card may only stay the same; clearing is handled as all-blank.
        assign chg[k]      = (slot_q[k] != BLANK) && (dec.rank != slot_q[k]);
    end

    logic       all_blank, order_err, win_any, four_dealt;
    logic [3:0] pscore_n, dscore_n;
    logic [1:0] exp_win;
    logic [2:0] deal_err;

    assign all_blank  = (slot_seg == {NUM_SLOTS{SEG_BLANK}});
    assign four_dealt = &filled[3:0];
    // p3 and d3 each need only the first four cards.
    assign order_err  = (filled[1] && !filled[0])
                      | (filled[2] && !(&filled[1:0]))
                      | (filled[3] && !(&filled[2:0]))
                      | ((filled[4] || filled[5]) && !four_dealt);
    assign pscore_n   = hand_score(rank_value(new_rank[0]), rank_value(new_rank[2]),
                                   rank_value(new_rank[4]));
    assign dscore_n   = hand_score(rank_value(new_rank[1]), rank_value(new_rank[3]),
                                   rank_value(new_rank[5]));
    assign win_any    = led[8] | led[9];
    assign exp_win    = (pscore_n > dscore_n) ? 2'b01 :
                        (dscore_n > pscore_n) ? 2'b10 : 2'b11;

    always_comb begin
        deal_err = ERR_NONE;
        if (|bad)
            deal_err = ERR_BADSEG;
        else if ((|chg) || order_err)
            deal_err = ERR_ORDER;
        else if (win_any && ($countones(filled) < 4))
            deal_err = ERR_EARLYWIN;
        else if (four_dealt && (led[3:0] != pscore_n || led[7:4] != dscore_n))
            deal_err = ERR_SCORE;
        else if (win_any && (led[9:8] != exp_win))
            deal_err = ERR_WINNER;
    end

    logic [2:0] err_hit;
    logic [3:0] pscore_d, dscore_d;
    logic       round_done_d;
    logic [7:0] rounds_d;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        pscore_d     = pscore_exp;
        dscore_d     = dscore_exp;
        err_hit      = ERR_NONE;
        round_done_d = 1'b0;
        rounds_d     = rounds;
        if (snap_valid) begin
            if (all_blank) begin
                // Game reset or end of round: forget the hand, no error.
                state_d  = S_IDLE;
                slot_d   = '0;
                pscore_d = '0;
                dscore_d = '0;
            end else if (state_q == S_DONE) begin
                err_hit = (|bad) ? ERR_BADSEG : ERR_ORDER;
            end else begin
                state_d  = S_DEAL;
                slot_d   = new_rank;
                pscore_d = pscore_n;
                dscore_d = dscore_n;
                err_hit  = deal_err;
                // The winner check is folded into deal_err, so the round closes here.
                if (win_any) begin
                    state_d      = S_DONE;
                    round_done_d = 1'b1;
                    if (rounds != 8'hFF)
                        rounds_d = rounds + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            pscore_exp <= '0;
            dscore_exp <= '0;
            round_done <= 1'b0;
            rounds     <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            pscore_exp <= pscore_d;
            dscore_exp <= dscore_d;
            round_done <= round_done_d;
            rounds     <= rounds_d;
            if (!err && err_hit != ERR_NONE) begin
                err      <= 1'b1;
                err_code <= err_hit;
            end
        end
    end

endmodule

// File: tb/tb_baccarat_hex_checker.sv
module tb_baccarat_hex_checker;

    localparam int STABLE = 8;
    localparam int SYNC   = 2;
    localparam int HOLD   = STABLE + SYNC + 10;

    logic       CLOCK_50 = 1'b0;
    logic       resetb;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;
    logic       snap_valid, round_done, err;
    logic [3:0] pscore_exp, dscore_exp;
    logic [7:0] rounds;
    logic [2:0] err_code;

    always #5 CLOCK_50 = ~CLOCK_50;

    baccarat_hex_checker #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetb     (resetb),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5),
        .LEDR       (LEDR),
        .snap_valid (snap_valid),
        .pscore_exp (pscore_exp),
        .dscore_exp (dscore_exp),
        .round_done (round_done),
        .rounds     (rounds),
        .err        (err),
        .err_code   (err_code)
    );

    // Segment pattern for each rank, index = rank (0 = blank, 1 = A ... 13 = K).
    logic [6:0] SEGS [14] = '{7'h7F, 7'h08, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                              7'h78, 7'h00, 7'h10, 7'h40, 7'h61, 7'h18, 7'h09};
    logic [51:0] BLANK_BUS = {10'd0, {42{1'b1}}};

    typedef struct {
        int ps, ds, e, code, rnd, rd;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0, sv_count = 0;

    // Reference model: game phase 0 = no cards, 1 = dealing, 2 = finished.
    int          m_slot[6];
    int          m_ps, m_ds, m_rounds, m_code, m_phase;
    bit          m_err;
    logic [51:0] m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, want);
        end
    endtask

    function automatic int cv(input int r);
        return (r >= 1 && r <= 9) ? r : 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 6; k++) m_slot[k] = 0;
        m_ps = 0; m_ds = 0; m_phase = 0;
    endtask

    task automatic model_snap(input logic [6:0] h [6], input logic [9:0] led);
        int ord[6] = '{0, 3, 1, 4, 2, 5};
        int pr[5]  = '{1, 2, 5, 3, 4};
        int r[6];
        bit e[6];
        bit bad, blank, win;
        int p, d, cnt, rk, want, rd;
        exp_t x;
        bad = 0; blank = 1; rd = 0; cnt = 0;
        for (int k = 0; k < 6; k++) e[k] = 0;
        for (int k = 0; k < 6; k++) begin
            rk = -1;
            for (int j = 0; j < 14; j++) if (SEGS[j] == h[ord[k]]) rk = j;
            if (rk < 0) begin bad = 1; rk = 0; end
            r[k] = rk;
            if (h[ord[k]] != 7'h7F) blank = 0;
        end
        if (blank) begin
            model_clear();
        end else if (m_phase == 2) begin
            if (bad) e[1] = 1; else e[2] = 1;
        end else begin
            if (bad) e[1] = 1;
            for (int k = 0; k < 6; k++) begin
                if (r[k] != 0) cnt++;
                if (m_slot[k] != 0 && r[k] != m_slot[k]) e[2] = 1;
                if (r[k] != 0)
                    for (int j = 0; j < ((k < 4) ? k : 4); j++) if (r[j] == 0) e[2] = 1;
            end
            p = (cv(r[0]) + cv(r[2]) + cv(r[4])) % 10;
            d = (cv(r[1]) + cv(r[3]) + cv(r[5])) % 10;
            win = led[9] | led[8];
            if (win && cnt < 4) e[5] = 1;
            if (r[0] != 0 && r[1] != 0 && r[2] != 0 && r[3] != 0 &&
                (led[3:0] != p || led[7:4] != d)) e[3] = 1;
            if (win) begin
                want = (p > d) ? 1 : (d > p) ? 2 : 3;
                if (led[9:8] != want) e[4] = 1;
                rd = 1;
                if (m_rounds < 255) m_rounds++;
            end
            for (int k = 0; k < 6; k++) m_slot[k] = r[k];
            m_ps = p; m_ds = d;
            m_phase = win ? 2 : 1;
        end
        for (int i = 0; i < 5; i++)
            if (!m_err && e[pr[i]]) begin m_err = 1; m_code = pr[i]; end
        x.ps = m_ps; x.ds = m_ds; x.e = m_err; x.code = m_code; x.rnd = m_rounds; x.rd = rd;
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic [6:0] h0, h1, h2, h3, h4, h5, input logic [9:0] led);
        HEX0 = h0; HEX1 = h1; HEX2 = h2; HEX3 = h3; HEX4 = h4; HEX5 = h5; LEDR = led;
    endtask

    task automatic present(input logic [6:0] h0, h1, h2, h3, h4, h5, input logic [9:0] led);
        logic [6:0]  h [6];
        logic [51:0] bus;
        @(negedge CLOCK_50);
        drive(h0, h1, h2, h3, h4, h5, led);
        h   = '{h0, h1, h2, h3, h4, h5};
        bus = {led, h5, h4, h3, h2, h1, h0};
        if (bus !== m_last) begin
            m_last = bus;
            model_snap(h, led);
        end
        repeat (HOLD) @(posedge CLOCK_50);
    endtask

    // Ranks in deal order; w < 0 lights the correct winner, bump corrupts the player score.
    task automatic show(input int p1, d1, p2, d2, p3, d3, input int w, input int bump);
        int p, d;
        logic [1:0] wl;
        p  = (cv(p1) + cv(p2) + cv(p3)) % 10;
        d  = (cv(d1) + cv(d2) + cv(d3)) % 10;
        wl = (w < 0) ? ((p > d) ? 2'b01 : (d > p) ? 2'b10 : 2'b11) : 2'(w);
        present(SEGS[p1], SEGS[p2], SEGS[p3], SEGS[d1], SEGS[d2], SEGS[d3],
                {wl, 4'(d), 4'((p + bump) % 16)});
    endtask

    task automatic do_reset(input bit check_zero);
        @(negedge CLOCK_50);
        resetb = 1'b0;
        drive(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 10'd0);
        #2;
        if (check_zero) begin
            chk("rst_snap_valid", snap_valid, 0);
            chk("rst_pscore", pscore_exp, 0);
            chk("rst_dscore", dscore_exp, 0);
            chk("rst_round_done", round_done, 0);
            chk("rst_rounds", rounds, 0);
            chk("rst_err", err, 0);
            chk("rst_err_code", err_code, 0);
        end
        model_clear();
        m_rounds = 0; m_err = 0; m_code = 0; m_last = BLANK_BUS;
        repeat (3) @(negedge CLOCK_50);
        resetb = 1'b1;
        repeat (3) @(posedge CLOCK_50);
    endtask

    // Monitor: every accepted snapshot is checked one cycle later against the queue.
    initial begin : monitor
        bit   pending;
        exp_t x;
        pending = 0;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (pending) begin
                x = exp_q.pop_front();
                chk("pscore_exp", pscore_exp, x.ps);
                chk("dscore_exp", dscore_exp, x.ds);
                chk("err", err, x.e);
                chk("err_code", err_code, x.code);
                chk("rounds", rounds, x.rnd);
                chk("round_done", round_done, x.rd);
                pending = 0;
            end else if (resetb) begin
                chk("round_done_idle", round_done, 0);
            end
            if (snap_valid) begin
                sv_count++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL snap_valid_unexpected actual=1 required=0");
                end else begin
                    pending = 1;
                end
            end
        end
    end

    initial begin : stim
        int c[6], cur[6], base, bump;
        resetb = 1'b1;
        drive(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 10'd0);
        do_reset(1);

        // Full round, dealer wins 2 to 0.
        show(1, 0, 0, 0, 0, 0, 0, 0);
        show(1, 2, 0, 0, 0, 0, 0, 0);
        show(1, 2, 3, 0, 0, 0, 0, 0);
        show(1, 2, 3, 4, 0, 0, 0, 0);
        show(1, 2, 3, 4, 6, 0, 0, 0);
        show(1, 2, 3, 4, 6, 6, 0, 0);
        show(1, 2, 3, 4, 6, 6, 2, 0);
        chk("t1_pscore", pscore_exp, 0);
        chk("t1_dscore", dscore_exp, 2);
        chk("t1_rounds", rounds, 1);
        chk("t1_err", err, 0);
        show(0, 0, 0, 0, 0, 0, 0, 0);

        // Illegal segment pattern.
        do_reset(0);
        present(7'h7E, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 10'd0);
        chk("t2_err_code", err_code, 1);

        // Out-of-order fills.
        do_reset(0);
        show(0, 0, 3, 0, 0, 0, 0, 0);
        chk("t3a_err_code", err_code, 2);
        do_reset(0);
        show(1, 0, 0, 0, 0, 0, 0, 0);
        show(1, 2, 0, 0, 0, 0, 0, 0);
        show(1, 2, 3, 0, 0, 0, 0, 0);
        show(1, 2, 3, 0, 5, 0, 0, 0);
        chk("t3b_err_code", err_code, 2);

        // Tie (5+K vs 5+10): wrong lights, then the correct ones.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(0);
            show(5, 0, 0, 0, 0, 0, 0, 0);
            show(5, 5, 0, 0, 0, 0, 0, 0);
            show(5, 5, 13, 0, 0, 0, 0, 0);
            show(5, 5, 13, 10, 0, 0, 0, 0);
            show(5, 5, 13, 10, 0, 0, (pass == 0) ? 1 : 3, 0);
            chk("t4_err_code", err_code, (pass == 0) ? 4 : 0);
        end

        // Bus toggling faster than the stability window, then held.
        do_reset(0);
        base = sv_count;
        for (int i = 0; i < 6; i++) begin
            repeat (STABLE / 2) @(negedge CLOCK_50);
            if (i % 2 == 0) drive(SEGS[1], 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 10'd1);
            else            drive(SEGS[1], 7'h7F, 7'h7F, SEGS[2], 7'h7F, 7'h7F, 10'h021);
        end
        repeat (STABLE / 2) @(negedge CLOCK_50);
        chk("t5_no_snap", sv_count - base, 0);
        show(1, 2, 0, 0, 0, 0, 0, 0);
        chk("t5_one_snap", sv_count - base, 1);

        // Abort mid-deal, then a full clean round, then reset during the deal.
        do_reset(0);
        show(7, 0, 0, 0, 0, 0, 0, 0);
        show(7, 9, 0, 0, 0, 0, 0, 0);
        show(0, 0, 0, 0, 0, 0, 0, 0);
        show(8, 0, 0, 0, 0, 0, 0, 0);
        show(8, 11, 0, 0, 0, 0, 0, 0);
        show(8, 11, 9, 0, 0, 0, 0, 0);
        show(8, 11, 9, 2, 0, 0, 0, 0);
        show(8, 11, 9, 2, 0, 0, -1, 0);
        chk("t6_rounds", rounds, 1);
        chk("t6_err", err, 0);
        show(0, 0, 0, 0, 0, 0, 0, 0);
        show(3, 0, 0, 0, 0, 0, 0, 0);
        do_reset(1);

        // Randomized rounds with occasional wrong scores, lights and aborts.
        for (int rnd = 0; rnd < 16; rnd++) begin
            if (rnd % 4 == 0) do_reset(0);
            for (int k = 0; k < 4; k++) c[k] = $urandom_range(1, 13);
            c[4] = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 13) : 0;
            c[5] = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 13) : 0;
            for (int k = 0; k < 6; k++) cur[k] = 0;
            for (int s = 0; s < 6; s++) begin
                if (c[s] == 0) continue;
                cur[s] = c[s];
                bump = ($urandom_range(0, 9) == 0) ? 1 : 0;
                show(cur[0], cur[1], cur[2], cur[3], cur[4], cur[5], 0, bump);
            end
            if ($urandom_range(0, 5) != 0)
                show(cur[0], cur[1], cur[2], cur[3], cur[4], cur[5],
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1, 0);
            show(0, 0, 0, 0, 0, 0, 0, 0);
        end

        repeat (HOLD) @(posedge CLOCK_50);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
